// File: rtl/img_pix_proc_if.sv
// Stream and configuration bundle for img_pix_proc.
// master drives pixels/config and samples results; slave is the pixel processor.
interface img_pix_proc_if #(
  parameter int DW  = 8,
  parameter int FCW = 16
);
  logic           InVSYNC;
  logic           InHSYNC;
  logic           InEN;
  logic [DW-1:0]  InData;
  logic           CFG_VALID;
  logic [1:0]     CFG_ADDR;
  logic [DW-1:0]  CFG_DATA;
  logic           OutVSYNC;
  logic           OutHSYNC;
  logic           OutEN;
  logic [DW-1:0]  OutData;
  logic [1:0]     ActMode;
  logic [FCW-1:0] FrameCnt;

  modport master (
    output InVSYNC, InHSYNC, InEN, InData, CFG_VALID, CFG_ADDR, CFG_DATA,
    input  OutVSYNC, OutHSYNC, OutEN, OutData, ActMode, FrameCnt
  );

  modport slave (
    input  InVSYNC, InHSYNC, InEN, InData, CFG_VALID, CFG_ADDR, CFG_DATA,
    output OutVSYNC, OutHSYNC, OutEN, OutData, ActMode, FrameCnt
  );
endinterface

// File: rtl/img_pix_proc.sv
// Per-pixel bypass/invert/threshold/offset path with fixed latency LAT and
// double-buffered configuration committed on every InVSYNC rising edge.
module img_pix_proc #(
  parameter int DW  = 8,
  parameter int LAT = 2,
  parameter int FCW = 16
) (
  input logic         clk_sys,
  input logic         reset_sys,
  img_pix_proc_if.slave pif
);
  localparam logic [DW-1:0] MAX     = {DW{1'b1}};
  localparam logic [DW-1:0] THR_RST = {1'b1, {(DW-1){1'b0}}};

  logic            vs_d_q;
  logic            vs_rise;
  logic [1:0]      sh_mode_q, sh_mode_d;
  logic [DW-1:0]   sh_thr_q, sh_thr_d;
  logic [DW-1:0]   sh_ofs_q, sh_ofs_d;
  logic [1:0]      act_mode_q, act_mode_d;
  logic [DW-1:0]   act_thr_q, act_thr_d;
  logic [DW-1:0]   act_ofs_q, act_ofs_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [DW+1:0]   sum;
  logic [DW-1:0]   pix_d;

  logic [DW-1:0]   dat_q [LAT];
  logic [LAT-1:0]  vs_q, hs_q, en_q;

  assign vs_rise = pif.InVSYNC & ~vs_d_q;

  always_comb begin
    sh_mode_d = sh_mode_q;
    sh_thr_d  = sh_thr_q;
    sh_ofs_d  = sh_ofs_q;
    if (pif.CFG_VALID) begin
      case (pif.CFG_ADDR)
        2'd0:    sh_mode_d = pif.CFG_DATA[1:0];
        2'd1:    sh_thr_d  = pif.CFG_DATA;
        2'd2:    sh_ofs_d  = pif.CFG_DATA;
        default: ;
      endcase
    end
    // A write coinciding with frame start passes straight into the active set.
    act_mode_d = vs_rise ? sh_mode_d : act_mode_q;
    act_thr_d  = vs_rise ? sh_thr_d  : act_thr_q;
    act_ofs_d  = vs_rise ? sh_ofs_d  : act_ofs_q;
    fcnt_d     = fcnt_q + {{(FCW-1){1'b0}}, vs_rise};
  end

  // Stage-1 operation uses the values that become active this cycle, so the
  // frame-start pixel already sees the newly committed settings.
  always_comb begin
    sum   = {2'b00, pif.InData} + {{2{act_ofs_d[DW-1]}}, act_ofs_d};
    pix_d = pif.InData;
    case (act_mode_d)
      2'd0: pix_d = pif.InData;
      2'd1: pix_d = MAX - pif.InData;
      2'd2: pix_d = (pif.InData >= act_thr_d) ? MAX : '0;
      default: begin
        if (sum[DW+1])    pix_d = '0;
        else if (sum[DW]) pix_d = MAX;
        else              pix_d = sum[DW-1:0];
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      vs_d_q     <= 1'b0;
      sh_mode_q  <= '0;
      sh_thr_q   <= THR_RST;
      sh_ofs_q   <= '0;
      act_mode_q <= '0;
      act_thr_q  <= THR_RST;
      act_ofs_q  <= '0;
      fcnt_q     <= '0;
    end else begin
      vs_d_q     <= pif.InVSYNC;
      sh_mode_q  <= sh_mode_d;
      sh_thr_q   <= sh_thr_d;
      sh_ofs_q   <= sh_ofs_d;
      act_mode_q <= act_mode_d;
      act_thr_q  <= act_thr_d;
      act_ofs_q  <= act_ofs_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
      vs_q <= '0;
      hs_q <= '0;
      en_q <= '0;
    end else begin
      dat_q[0] <= pix_d;
      vs_q[0]  <= pif.InVSYNC;
      hs_q[0]  <= pif.InHSYNC;
      en_q[0]  <= pif.InEN;
      for (int i = 1; i < LAT; i++) begin
        dat_q[i] <= dat_q[i-1];
        vs_q[i]  <= vs_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        en_q[i]  <= en_q[i-1];
      end
    end
  end

  assign pif.OutVSYNC = vs_q[LAT-1];
  assign pif.OutHSYNC = hs_q[LAT-1];
  assign pif.OutEN    = en_q[LAT-1];
  assign pif.OutData  = en_q[LAT-1] ? dat_q[LAT-1] : '0;
  assign pif.ActMode  = act_mode_q;
  assign pif.FrameCnt = fcnt_q;
endmodule

// File: tb/tb_img_pix_proc.sv
// Directed plus randomized bench for img_pix_proc against a frame-level
// reference model (config set per frame, latency queue of expected pixels).
module tb_img_pix_proc;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int FCW = 4;
  localparam int MAXV = (1 << DW) - 1;

  typedef struct {
    logic          vs;
    logic          hs;
    logic          en;
    logic [DW-1:0] d;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_sys;
  int   checks = 0;
  int   errors = 0;

  img_pix_proc_if #(.DW(DW), .FCW(FCW)) pif ();

  img_pix_proc #(.DW(DW), .LAT(LAT), .FCW(FCW)) dut (
    .clk_sys   (clk_sys),
    .reset_sys (reset_sys),
    .pif       (pif)
  );

  always #5 clk_sys = ~clk_sys;

  // reference state: shadow and active settings, frame counter, sync history
  int   m_sh_mode, m_sh_thr, m_sh_ofs;
  int   m_mode, m_thr, m_ofs;
  int   m_fcnt;
  logic m_prev_vs;
  exp_t expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pix(input int mode, input int thr, input int ofs, input int d);
    int o, r;
    case (mode)
      0: r = d;
      1: r = MAXV - d;
      2: r = (d >= thr) ? MAXV : 0;
      default: begin
        o = (ofs > MAXV / 2) ? ofs - (MAXV + 1) : ofs;
        r = d + o;
        if (r < 0) r = 0;
        if (r > MAXV) r = MAXV;
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    exp_t z;
    m_sh_mode = 0; m_sh_thr = 1 << (DW - 1); m_sh_ofs = 0;
    m_mode = 0;    m_thr = 1 << (DW - 1);    m_ofs = 0;
    m_fcnt = 0;
    m_prev_vs = 1'b0;
    expq.delete();
    z.vs = 1'b0; z.hs = 1'b0; z.en = 1'b0; z.d = '0;
    for (int i = 0; i < LAT - 1; i++) expq.push_back(z);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_vs"},   pif.OutVSYNC, 0);
    chk({tag, "_hs"},   pif.OutHSYNC, 0);
    chk({tag, "_en"},   pif.OutEN, 0);
    chk({tag, "_data"}, pif.OutData, 0);
  endtask

  // One clock: drive inputs, advance the model, then check the output slot.
  task automatic step(input logic vs, input logic hs, input logic en, input logic [DW-1:0] d,
                      input logic cv, input logic [1:0] ca, input logic [DW-1:0] cd);
    exp_t e, o;
    @(negedge clk_sys);
    pif.InVSYNC = vs; pif.InHSYNC = hs; pif.InEN = en; pif.InData = d;
    pif.CFG_VALID = cv; pif.CFG_ADDR = ca; pif.CFG_DATA = cd;
    if (cv) begin
      if (ca == 2'd0) m_sh_mode = int'(cd[1:0]);
      else if (ca == 2'd1) m_sh_thr = int'(cd);
      else if (ca == 2'd2) m_sh_ofs = int'(cd);
    end
    if (vs && !m_prev_vs) begin
      m_mode = m_sh_mode; m_thr = m_sh_thr; m_ofs = m_sh_ofs;
      m_fcnt = (m_fcnt + 1) % (1 << FCW);
    end
    m_prev_vs = vs;
    e.vs = vs; e.hs = hs; e.en = en;
    e.d = en ? DW'(ref_pix(m_mode, m_thr, m_ofs, int'(d))) : '0;
    expq.push_back(e);
    @(posedge clk_sys);
    #1;
    o = expq.pop_front();
    chk("out_vs",    pif.OutVSYNC, o.vs);
    chk("out_hs",    pif.OutHSYNC, o.hs);
    chk("out_en",    pif.OutEN, o.en);
    chk("out_data",  pif.OutData, o.d);
    chk("act_mode",  pif.ActMode, m_mode);
    chk("frame_cnt", pif.FrameCnt, m_fcnt);
  endtask

  task automatic px(input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b1, d, 1'b0, 2'd0, '0);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b0, 1'b0, DW'($urandom), 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, DW'($urandom), 1'b0, 2'd0, '0);
  endtask

  task automatic frame_start();
    step(1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0, 2'd0, '0);
    step(1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0, 2'd0, '0);
    step(1'b0, 1'b0, 1'b0, DW'($urandom), 1'b0, 2'd0, '0);
  endtask

  task automatic frame_rand(input int npix);
    logic cv;
    cv = ($urandom_range(0, 3) == 0);
    step(1'b1, 1'b0, 1'b0, DW'($urandom), cv, 2'($urandom), DW'($urandom));
    step(1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0, 2'd0, '0);
    for (int i = 0; i < npix; i++) begin
      cv = ($urandom_range(0, 4) == 0);
      step(1'b0, 1'b1, ($urandom_range(0, 5) != 0), DW'($urandom),
           cv, 2'($urandom), DW'($urandom));
    end
    idle(1);
  endtask

  initial begin
    reset_sys = 1'b1;
    pif.InVSYNC = 1'b0; pif.InHSYNC = 1'b0; pif.InEN = 1'b0; pif.InData = '0;
    pif.CFG_VALID = 1'b0; pif.CFG_ADDR = '0; pif.CFG_DATA = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_zero_outputs("rst");
    chk("rst_mode", pif.ActMode, 0);
    chk("rst_fcnt", pif.FrameCnt, 0);
    reset_sys = 1'b0;

    // bypass line
    for (int i = 0; i < 16; i++) px(DW'(i));
    idle(3);

    // invert: written mid-frame, pixels stay bypassed until the next frame start
    cfg(2'd0, 8'd1);
    px(8'h55); px(8'h0F);
    frame_start();
    px(8'h00); px(8'h3C); px(8'hFF);
    idle(2);

    // threshold
    cfg(2'd1, 8'h80);
    cfg(2'd0, 8'd2);
    frame_start();
    px(8'h7F); px(8'h80); px(8'h81);
    idle(2);

    // saturating offset, positive then negative
    cfg(2'd2, 8'h14);
    cfg(2'd0, 8'd3);
    frame_start();
    px(8'hF0); px(8'h10);
    cfg(2'd2, 8'hEC);
    frame_start();
    px(8'h10); px(8'h30);
    idle(2);

    // back to bypass, then a write landing on the frame-start cycle
    cfg(2'd0, 8'd0);
    frame_start();
    px(8'h21);
    step(1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 2'd0, 8'd1);
    px(8'h34);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 8'hFF);
    frame_start();
    px(8'h40);
    idle(2);

    // masking: invalid pixels never leak through
    step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 2'd0, '0);
    step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 2'd0, '0);
    px(8'h77);

    // asynchronous reset in the middle of a line
    px(8'h99);
    #2;
    reset_sys = 1'b1;
    #1;
    check_zero_outputs("midrst");
    chk("midrst_mode", pif.ActMode, 0);
    chk("midrst_fcnt", pif.FrameCnt, 0);
    @(negedge clk_sys);
    pif.InVSYNC = 1'b0; pif.InHSYNC = 1'b0; pif.InEN = 1'b0; pif.InData = '0;
    pif.CFG_VALID = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset_sys = 1'b0;
    model_reset();
    idle(2);

    // randomized frames; exactly 2^FCW frame starts bring the counter back to 0
    for (int f = 0; f < (1 << FCW); f++) frame_rand($urandom_range(4, 20));
    chk("fcnt_wrap", pif.FrameCnt, 0);
    for (int f = 0; f < 6; f++) frame_rand($urandom_range(4, 20));
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
